// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive/transmit pair: FSM states,
// default divider width and the parity helper used on both sides.
package uart_pkg;

    localparam int unsigned DEFAULT_DIVIDER_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } uart_state_e;

    // Parity bit value that makes the total count of ones (data + parity)
    // even when even=1, odd when even=0.
    function automatic logic parity_of(input logic [7:0] data, input logic even);
        return even ? (^data) : ~(^data);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line. Flops reset
// to 1 so the line reads as idle while reset is held.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] stages;

    // Shift the raw line through the synchroniser chain.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, centre sampling of start/data/parity/
// stop bits, held byte with parity/frame flags, valid and overrun handling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DIVIDER_WIDTH = DEFAULT_DIVIDER_WIDTH
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     serial_i,
    input  logic                     read_i,
    input  logic                     two_stop_bits_i,
    input  logic                     parity_bit_i,
    input  logic                     parity_even_i,
    input  logic [DIVIDER_WIDTH-1:0] clock_divider_i,
    output logic [7:0]               data_o,
    output logic                     valid_o,
    output logic                     parity_error_o,
    output logic                     frame_error_o,
    output logic                     overrun_o,
    output logic                     busy_o
);

    logic                     rx;
    logic                     rx_prev;
    uart_state_e              state;
    uart_state_e              state_next;
    logic [DIVIDER_WIDTH-1:0] count;
    logic [DIVIDER_WIDTH-1:0] period;
    logic [DIVIDER_WIDTH-1:0] period_eff;
    logic [DIVIDER_WIDTH-1:0] half_m1;
    logic [DIVIDER_WIDTH-1:0] period_m1;
    logic [2:0]               bit_idx;
    logic [7:0]               shreg;
    logic                     parity_en;
    logic                     parity_even;
    logic                     two_stop;
    logic                     parity_err;
    logic                     frame_err;
    logic                     start_det;
    logic                     bit_end;
    logic                     complete;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .async_i   (serial_i),
        .sync_o    (rx)
    );

    assign period_eff = (clock_divider_i < DIVIDER_WIDTH'(2)) ? DIVIDER_WIDTH'(2) : clock_divider_i;
    assign half_m1    = (period >> 1) - DIVIDER_WIDTH'(1);
    assign period_m1  = period - DIVIDER_WIDTH'(1);
    assign start_det  = (state == ST_IDLE) && rx_prev && !rx;
    assign bit_end    = (state == ST_START) ? (count == half_m1) : (count == period_m1);
    assign busy_o     = (state != ST_IDLE);

    // FSM state register.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completion fires at the centre of the last stop bit
    // so a start edge right after it is still seen from IDLE.
    always_comb begin
        state_next = state;
        complete   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_det) state_next = ST_START;
            end
            ST_START: begin
                if (bit_end) state_next = rx ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) state_next = parity_en ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP1;
            end
            ST_STOP1: begin
                if (bit_end) begin
                    if (two_stop) begin
                        state_next = ST_STOP2;
                    end else begin
                        state_next = ST_IDLE;
                        complete   = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (bit_end) begin
                    state_next = ST_IDLE;
                    complete   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bit timing, config latch on start edge, shift register and per-frame flags.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_prev     <= 1'b1;
            count       <= '0;
            period      <= DIVIDER_WIDTH'(2);
            bit_idx     <= '0;
            shreg       <= '0;
            parity_en   <= 1'b0;
            parity_even <= 1'b0;
            two_stop    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_prev <= rx;
            if (start_det) begin
                count       <= '0;
                period      <= period_eff;
                parity_en   <= parity_bit_i;
                parity_even <= parity_even_i;
                two_stop    <= two_stop_bits_i;
                bit_idx     <= '0;
                parity_err  <= 1'b0;
                frame_err   <= 1'b0;
            end else if (state != ST_IDLE) begin
                count <= bit_end ? '0 : count + DIVIDER_WIDTH'(1);
                if (bit_end) begin
                    case (state)
                        ST_DATA: begin
                            shreg   <= {rx, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                        ST_PARITY: parity_err <= (rx != parity_of(shreg, parity_even));
                        ST_STOP1, ST_STOP2: begin
                            if (!rx) frame_err <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Host-facing holding registers, valid handshake and overrun pulse.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o         <= '0;
            valid_o        <= 1'b0;
            parity_error_o <= 1'b0;
            frame_error_o  <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            overrun_o <= complete && valid_o && !read_i;
            if (complete) begin
                data_o         <= shreg;
                parity_error_o <= parity_err;
                frame_error_o  <= frame_err | ~rx;
                valid_o        <= 1'b1;
            end else if (read_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed loopback-style frames plus
// randomized frames, checked against a frame-level reference model.
module tb_uart_rx;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic        serial_i;
    logic        read_i;
    logic        two_stop_bits_i;
    logic        parity_bit_i;
    logic        parity_even_i;
    logic [15:0] clock_divider_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        parity_error_o;
    logic        frame_error_o;
    logic        overrun_o;
    logic        busy_o;

    int checks     = 0;
    int errors     = 0;
    int ovr_cycles = 0;

    // Reference model state
    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_perr  = 1'b0;
    logic       exp_ferr  = 1'b0;
    int         exp_ovr   = 0;

    uart_rx #(
        .SYNC_STAGES   (2),
        .DIVIDER_WIDTH (16)
    ) dut (
        .clock_i         (clock_i),
        .reset_n_i       (reset_n_i),
        .serial_i        (serial_i),
        .read_i          (read_i),
        .two_stop_bits_i (two_stop_bits_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
        .clock_divider_i (clock_divider_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .parity_error_o  (parity_error_o),
        .frame_error_o   (frame_error_o),
        .overrun_o       (overrun_o),
        .busy_o          (busy_o)
    );

    always #5 clock_i = ~clock_i;

    // Count cycles with overrun high; a correct 1-clock pulse adds exactly one per event.
    always @(negedge clock_i) begin
        if (reset_n_i === 1'b1 && overrun_o === 1'b1) ovr_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    function automatic int eff_n(input logic [15:0] div);
        return (div < 16'd2) ? 2 : int'(div);
    endfunction

    // Drive one frame on the line and update the expected outputs.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic even,
                              input logic two, input logic flip, input logic [1:0] stop_low,
                              input logic [15:0] div);
        int   n;
        int   ones;
        logic pbit;
        n    = eff_n(div);
        ones = $countones(d);
        pbit = ((even ? (ones % 2) : (1 - ones % 2)) != 0);
        clock_divider_i = div;
        parity_bit_i    = pen;
        parity_even_i   = even;
        two_stop_bits_i = two;
        serial_i = 1'b0;
        tick(n);
        for (int j = 0; j < 8; j++) begin
            serial_i = d[j];
            tick(n);
            if (j == 1) begin
                clock_divider_i = 16'($urandom_range(0, 9));
                parity_bit_i    = 1'($urandom);
                parity_even_i   = 1'($urandom);
                two_stop_bits_i = 1'($urandom);
            end
        end
        if (pen) begin
            serial_i = pbit ^ flip;
            tick(n);
        end
        serial_i = ~stop_low[0];
        tick(n);
        if (two) begin
            serial_i = ~stop_low[1];
            tick(n);
        end
        serial_i = 1'b1;
        if (exp_valid) exp_ovr++;
        exp_valid = 1'b1;
        exp_data  = d;
        exp_perr  = pen & flip;
        exp_ferr  = stop_low[0] | (two & stop_low[1]);
    endtask

    task automatic check_frame(input string tag);
        check({tag, ".data"},  32'(data_o),         32'(exp_data));
        check({tag, ".valid"}, 32'(valid_o),        32'(exp_valid));
        check({tag, ".perr"},  32'(parity_error_o), 32'(exp_perr));
        check({tag, ".ferr"},  32'(frame_error_o),  32'(exp_ferr));
        check({tag, ".busy"},  32'(busy_o),         32'd0);
        check({tag, ".ovr"},   32'(ovr_cycles),     32'(exp_ovr));
    endtask

    task automatic do_read(input string tag);
        read_i = 1'b1;
        tick(1);
        read_i = 1'b0;
        exp_valid = 1'b0;
        tick(1);
        check({tag, ".valid"}, 32'(valid_o), 32'd0);
        check({tag, ".data"},  32'(data_o),  32'(exp_data));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".data"},  32'(data_o),         32'd0);
        check({tag, ".valid"}, 32'(valid_o),        32'd0);
        check({tag, ".perr"},  32'(parity_error_o), 32'd0);
        check({tag, ".ferr"},  32'(frame_error_o),  32'd0);
        check({tag, ".ovr"},   32'(overrun_o),      32'd0);
        check({tag, ".busy"},  32'(busy_o),         32'd0);
    endtask

    initial begin
        logic [7:0]  r_d;
        logic [15:0] r_div;
        logic        r_pen, r_even, r_two, r_flip;
        logic [1:0]  r_stop;
        logic        saw_busy;

        reset_n_i       = 1'b0;
        serial_i        = 1'b1;
        read_i          = 1'b0;
        two_stop_bits_i = 1'b0;
        parity_bit_i    = 1'b0;
        parity_even_i   = 1'b0;
        clock_divider_i = 16'd4;
        tick(3);
        check_reset_state("reset");
        reset_n_i = 1'b1;
        tick(4);

        // 1: odd parity, 0x55
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd4);
        tick(8);
        check_frame("t1");

        // 2: even parity, two stops, 0xAA, then read
        do_read("t2.pre");
        send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'd4);
        tick(8);
        check_frame("t2");
        do_read("t2.read");

        // 3: odd parity with inverted parity bit
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 16'd4);
        tick(8);
        check_frame("t3");
        do_read("t3.read");

        // 4: stop bit held low for a full bit period
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 16'd4);
        tick(8);
        check_frame("t4");
        do_read("t4.read");

        // 5: one-clock low glitch on the idle line
        serial_i = 1'b0;
        tick(1);
        serial_i = 1'b1;
        saw_busy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (busy_o) saw_busy = 1'b1;
        end
        check("t5.saw_busy", 32'(saw_busy), 32'd1);
        check_frame("t5");

        // Break: line held low well past a frame, then released
        clock_divider_i = 16'd4;
        parity_bit_i    = 1'b0;
        two_stop_bits_i = 1'b0;
        serial_i = 1'b0;
        tick(4 * 14);
        exp_valid = 1'b1;
        exp_data  = 8'h00;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b1;
        check_frame("brk");
        serial_i = 1'b1;
        tick(8);
        do_read("brk.read");
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd4);
        tick(8);
        check_frame("brk.after");
        do_read("brk.after.read");

        // 6: back-to-back frames without read -> overrun
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd4);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd4);
        tick(8);
        check_frame("t6");
        // Third frame aborted by reset midway
        serial_i = 1'b0;
        tick(4);
        serial_i = 1'b0;
        tick(4);
        serial_i = 1'b1;
        tick(4);
        reset_n_i = 1'b0;
        #2;
        check_reset_state("t6.rst");
        serial_i = 1'b1;
        tick(3);
        reset_n_i = 1'b1;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        tick(4);
        send_frame(8'h56, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd4);
        tick(8);
        check_frame("t6.after");

        // Randomized frames, reads and divider values (including N<2)
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) do_read("rnd.read");
            r_d    = 8'($urandom);
            r_div  = 16'($urandom_range(0, 7));
            r_pen  = 1'($urandom);
            r_even = 1'($urandom);
            r_two  = 1'($urandom);
            r_flip = ($urandom_range(0, 3) == 0);
            r_stop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            send_frame(r_d, r_pen, r_even, r_two, r_flip, r_stop, r_div);
            tick(eff_n(r_div) + 4);
            check_frame("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
